// File: rtl/stepper_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stepper_sequencer
// Description : Unipolar stepper driver with wave, full-step and half-step
//               sequencing, programmable period and bounded/continuous runs.
// Revision    : 1.0
// ============================================================================
module stepper_sequencer #(
    parameter int PERIOD_W   = 16,
    parameter int STEPS_W    = 16,
    parameter int POS_W      = 24,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit HOLD_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic                direction,
    input  logic [PERIOD_W-1:0] period,
    input  logic [STEPS_W-1:0]  steps,
    input  logic                continuous,
    input  logic                start,
    input  logic                stop,
    output logic [3:0]          drive,
    output logic                busy,
    output logic                done,
    output logic [POS_W-1:0]    position
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RUN  = 1'b1;
    localparam logic [3:0] c_OFF    = ACTIVE_LOW ? 4'b1111 : 4'b0000;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [2:0]          r_idx;
    logic [PERIOD_W-1:0] r_tick;
    logic [PERIOD_W-1:0] r_period;
    logic [STEPS_W-1:0]  r_remaining;
    logic [POS_W-1:0]    r_pos;
    logic [1:0]          r_mode;
    logic                r_cont;
    logic                r_done;
    logic                r_energised;

    logic                w_start_accept;
    logic                w_step;
    logic                w_done_next;
    logic [PERIOD_W-1:0] w_period_eff;
    logic [2:0]          w_inc;
    logic [2:0]          w_idx_next;
    logic [3:0]          w_coils;
    logic                w_on;

    assign w_period_eff = (period == '0) ? PERIOD_W'(1) : period;

    // Half-step always moves by one; wave/full jump two when already on the
    // target parity, otherwise one to snap onto it.
    always_comb begin
        w_inc = 3'd1;
        if (r_mode != 2'b10) begin
            w_inc = (r_idx[0] == (r_mode == 2'b01)) ? 3'd2 : 3'd1;
        end
        w_idx_next = direction ? (r_idx + w_inc) : (r_idx - w_inc);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_start_accept = 1'b0;
        w_step         = 1'b0;
        w_done_next    = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    if (steps == '0 && !continuous) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_start_accept = 1'b1;
                        w_state_next   = c_S_RUN;
                    end
                end
            end
            c_S_RUN: begin
                if (stop) begin
                    w_done_next  = 1'b1;
                    w_state_next = c_S_IDLE;
                end else if (r_tick == '0) begin
                    w_step = 1'b1;
                    if (!r_cont && r_remaining == STEPS_W'(1)) begin
                        w_done_next  = 1'b1;
                        w_state_next = c_S_IDLE;
                    end
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    // Datapath: latched run parameters, tick counter, phase index, position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= 3'd0;
            r_tick      <= '0;
            r_period    <= PERIOD_W'(1);
            r_remaining <= '0;
            r_pos       <= '0;
            r_mode      <= 2'b00;
            r_cont      <= 1'b0;
            r_energised <= 1'b0;
        end else if (w_start_accept) begin
            r_mode      <= mode;
            r_period    <= w_period_eff;
            r_cont      <= continuous;
            r_remaining <= steps;
            r_tick      <= w_period_eff - PERIOD_W'(1);
            r_energised <= 1'b1;
        end else if (w_step) begin
            r_idx  <= w_idx_next;
            r_pos  <= direction ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
            r_tick <= r_period - PERIOD_W'(1);
            if (!r_cont) begin
                r_remaining <= r_remaining - STEPS_W'(1);
            end
        end else if (r_state == c_S_RUN && !stop) begin
            r_tick <= r_tick - PERIOD_W'(1);
        end
    end

    // Output logic
    always_comb begin
        case (r_idx)
            3'd0:    w_coils = 4'b1000;
            3'd1:    w_coils = 4'b1100;
            3'd2:    w_coils = 4'b0100;
            3'd3:    w_coils = 4'b0110;
            3'd4:    w_coils = 4'b0010;
            3'd5:    w_coils = 4'b0011;
            3'd6:    w_coils = 4'b0001;
            default: w_coils = 4'b1001;
        endcase
        busy     = (r_state == c_S_RUN);
        w_on     = busy || (HOLD_EN && r_energised);
        drive    = w_on ? (ACTIVE_LOW ? ~w_coils : w_coils) : c_OFF;
        done     = r_done;
        position = r_pos;
    end

endmodule
`default_nettype wire

// File: tb/tb_stepper_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stepper_sequencer
// Description : Directed self-checking bench for stepper_sequencer, holding
//               and non-holding variants driven in lockstep.
// Revision    : 1.0
// ============================================================================
module tb_stepper_sequencer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic        direction;
    logic [15:0] period;
    logic [15:0] steps;
    logic        continuous;
    logic        start;
    logic        stop;
    logic [3:0]  drive_h;
    logic [3:0]  drive_n;
    logic        busy_h;
    logic        busy_n;
    logic        done_h;
    logic        done_n;
    logic [23:0] pos_h;
    logic [23:0] pos_n;

    int checks = 0;
    int errors = 0;

    stepper_sequencer #(.HOLD_EN(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .mode(mode), .direction(direction),
        .period(period), .steps(steps), .continuous(continuous),
        .start(start), .stop(stop), .drive(drive_h), .busy(busy_h),
        .done(done_h), .position(pos_h)
    );

    stepper_sequencer #(.HOLD_EN(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .mode(mode), .direction(direction),
        .period(period), .steps(steps), .continuous(continuous),
        .start(start), .stop(stop), .drive(drive_n), .busy(busy_n),
        .done(done_n), .position(pos_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] exp1 [8];

    initial begin
        exp1 = '{4'b0011, 4'b1011, 4'b1001, 4'b1101,
                 4'b1100, 4'b1110, 4'b0110, 4'b0111};
        rst_n = 1'b0; mode = 2'b00; direction = 1'b0; period = 16'd0;
        steps = 16'd0; continuous = 1'b0; start = 1'b0; stop = 1'b0;
        tick();
        tick();
        check("rst_drive_h", 32'(drive_h), 32'hF);
        check("rst_drive_n", 32'(drive_n), 32'hF);
        check("rst_busy", 32'(busy_h), 32'h0);
        check("rst_done", 32'(done_h), 32'h0);
        check("rst_pos", 32'(pos_h), 32'h0);
        rst_n = 1'b1;
        tick();

        // Half-step forward, period 4, 8 steps
        mode = 2'b10; direction = 1'b1; period = 16'd4; steps = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_start", 32'(busy_h), 32'h1);
        check("t1_drive_h0", 32'(drive_h), 32'h7);
        check("t1_drive_n0", 32'(drive_n), 32'h7);
        for (int k = 0; k < 8; k++) begin
            repeat (3) tick();
            check("t1_pre_busy", 32'(busy_h), 32'h1);
            check("t1_pre_pos", 32'(pos_h), 32'(k));
            tick();
            check("t1_drive", 32'(drive_h), 32'(exp1[k]));
            check("t1_pos", 32'(pos_h), 32'(k + 1));
            if (k < 7) check("t1_done_mid", 32'(done_h), 32'h0);
        end
        check("t1_busy_end", 32'(busy_h), 32'h0);
        check("t1_done", 32'(done_h), 32'h1);
        check("t1_done_n", 32'(done_n), 32'h1);
        check("t1_hold_off", 32'(drive_n), 32'hF);
        tick();
        check("t1_done_clr", 32'(done_h), 32'h0);
        check("t1_hold_keep", 32'(drive_h), 32'h7);

        // Wave backward, period 0 (treated as 1), 3 steps from index 0
        do_reset();
        mode = 2'b00; direction = 1'b0; period = 16'd0; steps = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_busy0", 32'(busy_h), 32'h1);
        tick();
        check("t2_drive6", 32'(drive_h), 32'hE);
        check("t2_busy1", 32'(busy_h), 32'h1);
        tick();
        check("t2_drive4", 32'(drive_h), 32'hD);
        check("t2_busy2", 32'(busy_h), 32'h1);
        tick();
        check("t2_drive2", 32'(drive_h), 32'hB);
        check("t2_busy3", 32'(busy_h), 32'h0);
        check("t2_done", 32'(done_h), 32'h1);
        check("t2_pos", 32'(pos_h), 32'h00FFFFFD);

        // Half-step to index 1, full-step to 3 and 5, wave snap to 6
        do_reset();
        mode = 2'b10; direction = 1'b1; period = 16'd1; steps = 16'd1;
        start = 1'b1; tick(); start = 1'b0; tick();
        check("t3_idx1", 32'(drive_h), 32'h3);
        check("t3_done1", 32'(done_h), 32'h1);
        mode = 2'b01; steps = 16'd2;
        start = 1'b1; tick(); start = 1'b0; tick();
        check("t3_idx3", 32'(drive_h), 32'h9);
        tick();
        check("t3_idx5", 32'(drive_h), 32'hC);
        check("t3_done5", 32'(done_h), 32'h1);
        mode = 2'b00; steps = 16'd1;
        start = 1'b1; tick(); start = 1'b0; tick();
        check("t3_snap6", 32'(drive_h), 32'hE);
        check("t3_pos", 32'(pos_h), 32'h4);

        // Continuous half-step, period 10, stop on a due tick
        mode = 2'b10; direction = 1'b1; period = 16'd10; continuous = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        check("t4_step7", 32'(drive_h), 32'h6);
        check("t4_pos5", 32'(pos_h), 32'h5);
        repeat (9) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t4_busy", 32'(busy_h), 32'h0);
        check("t4_done", 32'(done_h), 32'h1);
        check("t4_pos", 32'(pos_h), 32'h5);
        check("t4_drive_h", 32'(drive_h), 32'h6);
        check("t4_drive_n", 32'(drive_n), 32'hF);
        tick();
        check("t4_done_clr", 32'(done_h), 32'h0);

        // Zero-length request
        continuous = 1'b0; steps = 16'd0;
        start = 1'b1; tick(); start = 1'b0;
        check("t5_done", 32'(done_h), 32'h1);
        check("t5_busy", 32'(busy_h), 32'h0);
        check("t5_drive", 32'(drive_h), 32'h6);
        tick();
        check("t5_busy2", 32'(busy_h), 32'h0);
        check("t5_done_clr", 32'(done_h), 32'h0);

        // start+stop together in IDLE, then reset mid-RUN
        period = 16'd2; steps = 16'd5;
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("t6_busy", 32'(busy_n), 32'h1);
        check("t6_drive_n", 32'(drive_n), 32'h6);
        tick(); tick();
        check("t6_step", 32'(drive_n), 32'h7);
        check("t6_pos", 32'(pos_n), 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_drive_n", 32'(drive_n), 32'hF);
        check("t6_rst_drive_h", 32'(drive_h), 32'hF);
        check("t6_rst_pos", 32'(pos_n), 32'h0);
        check("t6_rst_busy", 32'(busy_n), 32'h0);
        check("t6_rst_done", 32'(done_n), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_no_done", 32'(done_n), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
